vproc_mem_mmu: RTL and testbench



---
 rtl/vproc_mmu_pkg.sv | 43 ++++
 rtl/qspi_read_engine.sv | 128 ++++++++++++
 rtl/vproc_mem_mmu.sv | 194 +++++++++++++++++++
 tb/tb_vproc_mem_mmu.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_mmu_pkg.sv
// -----------------------------------------------------------------------------
// vproc_mmu_pkg
// Shared constants and types for the vector-processor memory-mapping unit:
// address map, QSPI command/timing constants, read-engine state encoding and
// the address decoder used by the top level.
// -----------------------------------------------------------------------------
package vproc_mmu_pkg;

    // Address map
    localparam logic [31:0] GPIO_ADDR  = 32'h0000_1000;
    localparam logic [31:0] FLASH_BASE = 32'h0000_2000;
    localparam logic [31:0] FLASH_SIZE = 32'h0100_0000;

    // Quad output fast read and its dummy-clock count
    localparam logic [7:0] QSPI_CMD_QREAD = 8'h6B;
    localparam int         DUMMY_CYCLES   = 8;

    // Read-engine states
    typedef logic [2:0] qspi_state_t;
    localparam qspi_state_t ST_IDLE  = 3'd0;
    localparam qspi_state_t ST_CMD   = 3'd1;
    localparam qspi_state_t ST_ADDR  = 3'd2;
    localparam qspi_state_t ST_DUMMY = 3'd3;
    localparam qspi_state_t ST_DATA  = 3'd4;
    localparam qspi_state_t ST_RESP  = 3'd5;

    typedef enum logic [1:0] {
        REGION_ERR,
        REGION_GPIO,
        REGION_FLASH
    } region_t;

    function automatic region_t decode_region(input logic [31:0] addr);
        if (addr == GPIO_ADDR) begin
            return REGION_GPIO;
        end
        if (addr >= FLASH_BASE && addr < FLASH_BASE + FLASH_SIZE) begin
            return REGION_FLASH;
        end
        return REGION_ERR;
    endfunction

endpackage

// File: rtl/qspi_read_engine.sv
// -----------------------------------------------------------------------------
// qspi_read_engine
// Performs one 32-bit quad output fast read (0x6B) from QSPI flash, SPI mode 0,
// SCK = clk/2. Command and address go out serially on io[0]; after the dummy
// clocks eight nibbles are read on io[3:0].
//
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   start         begin a read (honoured only while idle)
//   addr[23:0]    flash byte address
//   io_i[3:0]     flash data in
//   busy          engine not idle
//   done          one-cycle flag: data is complete, transaction ends this cycle
//   data[31:0]    read word, first byte received in [7:0]
//   io_o/io_t     flash data out / tristate (1 = released)
//   ck_o, cs_o    serial clock, active-low chip select
// -----------------------------------------------------------------------------
module qspi_read_engine
    import vproc_mmu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [3:0]  io_i,
    output logic        busy,
    output logic        done,
    output logic [31:0] data,
    output logic [3:0]  io_o,
    output logic [3:0]  io_t,
    output logic        ck_o,
    output logic        cs_o
);

    qspi_state_t state;
    logic [4:0]  bit_cnt;
    logic [31:0] tx_sh;   // command byte followed by the 24 address bits
    logic [31:0] rx_sh;   // nibbles in arrival order, first nibble at the top
    logic        ck_q;
    logic        cs_q;
    logic        io0_q;
    logic [3:0]  io_t_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            ck_q    <= 1'b0;
            cs_q    <= 1'b1;
            io0_q   <= 1'b0;
            io_t_q  <= 4'hF;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_CMD;
                        bit_cnt <= '0;
                        tx_sh   <= {QSPI_CMD_QREAD, addr};
                        io0_q   <= QSPI_CMD_QREAD[7];
                        io_t_q  <= 4'b1110;
                        cs_q    <= 1'b0;
                        ck_q    <= 1'b0;
                    end
                end
                // Trailing low half of the last SCK period, then deselect.
                ST_RESP: begin
                    state <= ST_IDLE;
                    cs_q  <= 1'b1;
                end
                default: begin
                    if (!ck_q) begin
                        // Rising SCK: the flash output is sampled on this edge.
                        ck_q <= 1'b1;
                        if (state == ST_DATA) begin
                            rx_sh <= {rx_sh[27:0], io_i};
                        end
                    end else begin
                        // Falling SCK: advance to the next bit or nibble.
                        ck_q    <= 1'b0;
                        bit_cnt <= bit_cnt + 5'd1;
                        case (state)
                            ST_CMD, ST_ADDR: begin
                                tx_sh <= {tx_sh[30:0], 1'b0};
                                io0_q <= tx_sh[30];
                                if (state == ST_CMD && bit_cnt == 5'd7) begin
                                    state   <= ST_ADDR;
                                    bit_cnt <= '0;
                                end
                                if (state == ST_ADDR && bit_cnt == 5'd23) begin
                                    state   <= ST_DUMMY;
                                    bit_cnt <= '0;
                                    io0_q   <= 1'b0;
                                    io_t_q  <= 4'hF;
                                end
                            end
                            ST_DUMMY: begin
                                if (bit_cnt == 5'(DUMMY_CYCLES - 1)) begin
                                    state   <= ST_DATA;
                                    bit_cnt <= '0;
                                end
                            end
                            ST_DATA: begin
                                if (bit_cnt == 5'd7) begin
                                    state <= ST_RESP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_RESP);
    // Each byte arrives high nibble first; the first byte is the least significant.
    assign data = {rx_sh[7:0], rx_sh[15:8], rx_sh[23:16], rx_sh[31:24]};
    assign io_o = {3'b000, io0_q};
    assign io_t = io_t_q;
    assign ck_o = ck_q;
    assign cs_o = cs_q;

endmodule

// File: rtl/vproc_mem_mmu.sv
// -----------------------------------------------------------------------------
// vproc_mem_mmu
// Maps the vector core's single memory port onto a 10-bit GPIO register and
// read-only quad-SPI flash. Flash reads go over the storage port or the
// programming port, chosen when the read starts. One request outstanding;
// exactly one rvalid per accepted request.
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   set_programming_mode         1 = flash reads use the programming port
//   set_debug_mode               pins show the last request address (debug build)
//   vproc_mem_req_o/addr_o/we_o/be_o/wdata_o   request from the core
//   vproc_mem_rvalid_i/err_i/rdata_i           response to the core
//   gpio_pins[9:0]               GPIO outputs
//   external_qspi_*              storage flash port
//   programming_qspi_*           programming flash port
//
// Build option: define MMU_DEBUG_EN to let set_debug_mode put addr[11:2] of the
// most recently accepted request on gpio_pins.
// -----------------------------------------------------------------------------
module vproc_mem_mmu
    import vproc_mmu_pkg::*;
#(
    parameter int MEM_W = 32   // only 32 is supported
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_programming_mode,
    input  logic             set_debug_mode,
    input  logic             vproc_mem_req_o,
    input  logic [31:0]      vproc_mem_addr_o,
    input  logic             vproc_mem_we_o,
    input  logic [3:0]       vproc_mem_be_o,
    input  logic [MEM_W-1:0] vproc_mem_wdata_o,
    output logic             vproc_mem_rvalid_i,
    output logic             vproc_mem_err_i,
    output logic [MEM_W-1:0] vproc_mem_rdata_i,
    output logic [9:0]       gpio_pins,
    input  logic [3:0]       external_qspi_io_i,
    output logic [3:0]       external_qspi_io_o,
    output logic [3:0]       external_qspi_io_t,
    output logic             external_qspi_ck_o,
    output logic             external_qspi_cs_o,
    input  logic [3:0]       programming_qspi_io_i,
    output logic [3:0]       programming_qspi_io_o,
    output logic [3:0]       programming_qspi_io_t,
    output logic             programming_qspi_ck_o,
    output logic             programming_qspi_cs_o
);

    region_t     region;
    logic        accept;
    logic [23:0] flash_off;

    logic        eng_start;
    logic        eng_busy;
    logic        eng_done;
    logic [31:0] eng_data;
    logic [3:0]  eng_io_i;
    logic [3:0]  eng_io_o;
    logic [3:0]  eng_io_t;
    logic        eng_ck;
    logic        eng_cs;

    logic             rvalid_q;
    logic             err_q;
    logic [MEM_W-1:0] rdata_q;
    logic [9:0]       gpio_q;
    logic             prog_sel_q;   // port of the current/last flash read

    assign region    = decode_region(vproc_mem_addr_o);
    // The engine stays busy through its response cycle, so a request can only
    // be accepted once the previous response has been issued.
    assign accept    = vproc_mem_req_o && !eng_busy;
    assign eng_start = accept && (region == REGION_FLASH) && !vproc_mem_we_o;
    // Offset modulo 2^24 only needs the low address bits; word-align it.
    assign flash_off = vproc_mem_addr_o[23:0] - FLASH_BASE[23:0];

    qspi_read_engine u_engine (
        .clk   (clk),
        .rst   (rst),
        .start (eng_start),
        .addr  ({flash_off[23:2], 2'b00}),
        .io_i  (eng_io_i),
        .busy  (eng_busy),
        .done  (eng_done),
        .data  (eng_data),
        .io_o  (eng_io_o),
        .io_t  (eng_io_t),
        .ck_o  (eng_ck),
        .cs_o  (eng_cs)
    );

`ifdef MMU_DEBUG_EN
    logic [9:0] dbg_addr_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            gpio_q     <= '0;
            prog_sel_q <= 1'b0;
`ifdef MMU_DEBUG_EN
            dbg_addr_q <= '0;
`endif
        end else begin
            // Response outputs are one-cycle; zero unless a response is issued.
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;

            if (eng_done) begin
                rvalid_q <= 1'b1;
                rdata_q  <= eng_data;
            end

            if (accept) begin
`ifdef MMU_DEBUG_EN
                dbg_addr_q <= vproc_mem_addr_o[11:2];
`endif
                case (region)
                    REGION_GPIO: begin
                        rvalid_q <= 1'b1;
                        if (vproc_mem_we_o) begin
                            if (vproc_mem_be_o[0]) gpio_q[7:0] <= vproc_mem_wdata_o[7:0];
                            if (vproc_mem_be_o[1]) gpio_q[9:8] <= vproc_mem_wdata_o[9:8];
                        end else begin
                            rdata_q <= {{(MEM_W-10){1'b0}}, gpio_q};
                        end
                    end
                    REGION_FLASH: begin
                        if (vproc_mem_we_o) begin
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b1;
                        end else begin
                            // Port choice is frozen for the whole transaction.
                            prog_sel_q <= set_programming_mode;
                        end
                    end
                    default: begin
                        rvalid_q <= 1'b1;
                        err_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        external_qspi_io_o    = 4'h0;
        external_qspi_io_t    = 4'hF;
        external_qspi_ck_o    = 1'b0;
        external_qspi_cs_o    = 1'b1;
        programming_qspi_io_o = 4'h0;
        programming_qspi_io_t = 4'hF;
        programming_qspi_ck_o = 1'b0;
        programming_qspi_cs_o = 1'b1;
        eng_io_i              = external_qspi_io_i;
        if (prog_sel_q) begin
            programming_qspi_io_o = eng_io_o;
            programming_qspi_io_t = eng_io_t;
            programming_qspi_ck_o = eng_ck;
            programming_qspi_cs_o = eng_cs;
            eng_io_i              = programming_qspi_io_i;
        end else begin
            external_qspi_io_o = eng_io_o;
            external_qspi_io_t = eng_io_t;
            external_qspi_ck_o = eng_ck;
            external_qspi_cs_o = eng_cs;
        end
    end

    assign vproc_mem_rvalid_i = rvalid_q;
    assign vproc_mem_err_i    = err_q;
    assign vproc_mem_rdata_i  = rdata_q;

`ifdef MMU_DEBUG_EN
    assign gpio_pins = set_debug_mode ? dbg_addr_q : gpio_q;

    logic unused_bits;
    assign unused_bits = ^{vproc_mem_wdata_o[MEM_W-1:10], vproc_mem_be_o[3:2], flash_off[1:0]};
`else
    assign gpio_pins = gpio_q;

    logic unused_bits;
    assign unused_bits = ^{vproc_mem_wdata_o[MEM_W-1:10], vproc_mem_be_o[3:2], flash_off[1:0],
                           set_debug_mode};
`endif

endmodule

// File: tb/tb_vproc_mem_mmu.sv
module tb_vproc_mem_mmu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        set_programming_mode = 1'b0;
    logic        set_debug_mode = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
    logic [9:0]  gpio;
    logic [3:0]  ext_io_i, ext_io_o, ext_io_t;
    logic        ext_ck, ext_cs;
    logic [3:0]  prg_io_i, prg_io_o, prg_io_t;
    logic        prg_ck, prg_cs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vproc_mem_mmu #(.MEM_W(32)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .set_programming_mode  (set_programming_mode),
        .set_debug_mode        (set_debug_mode),
        .vproc_mem_req_o       (req),
        .vproc_mem_addr_o      (addr),
        .vproc_mem_we_o        (we),
        .vproc_mem_be_o        (be),
        .vproc_mem_wdata_o     (wdata),
        .vproc_mem_rvalid_i    (rvalid),
        .vproc_mem_err_i       (err),
        .vproc_mem_rdata_i     (rdata),
        .gpio_pins             (gpio),
        .external_qspi_io_i    (ext_io_i),
        .external_qspi_io_o    (ext_io_o),
        .external_qspi_io_t    (ext_io_t),
        .external_qspi_ck_o    (ext_ck),
        .external_qspi_cs_o    (ext_cs),
        .programming_qspi_io_i (prg_io_i),
        .programming_qspi_io_o (prg_io_o),
        .programming_qspi_io_t (prg_io_t),
        .programming_qspi_ck_o (prg_ck),
        .programming_qspi_cs_o (prg_cs)
    );

    // ---------------- flash model (attached to the port chosen by model_sel)
    logic        model_sel = 1'b0;
    logic [3:0]  m_io = 4'h0;
    logic        m_prev_ck = 1'b0;
    int          bit_n = 0;
    logic [31:0] cap = '0;          // {command, address} as seen on io[0]
    logic [7:0]  fmem [0:4095];

    assign ext_io_i = model_sel ? 4'h0 : m_io;
    assign prg_io_i = model_sel ? m_io : 4'h0;

    always @(negedge clk) begin
        logic       m_ck, m_cs, m_d;
        int         j;
        logic [11:0] idx;
        logic [7:0] b;
        m_ck = model_sel ? prg_ck : ext_ck;
        m_cs = model_sel ? prg_cs : ext_cs;
        m_d  = model_sel ? prg_io_o[0] : ext_io_o[0];
        if (m_cs !== 1'b0) begin
            bit_n = 0;
            m_io  = 4'h0;
        end else if (m_ck === 1'b1 && m_prev_ck === 1'b0) begin
            if (bit_n < 32) cap = {cap[30:0], m_d};
            bit_n++;
        end else if (m_ck === 1'b0 && m_prev_ck === 1'b1 && bit_n >= 40 && bit_n < 48) begin
            j    = bit_n - 40;
            idx  = cap[11:0] + 12'(j / 2);
            b    = fmem[idx];
            m_io = (j % 2 == 0) ? b[7:4] : b[3:0];
        end
        m_prev_ck = m_ck;
    end

    // ---------------- bus activity monitor
    int   rvalid_cnt = 0;
    int   ext_rises = 0, ext_cs_falls = 0, ext_fall_cyc = 0, ext_rise_cyc = 0;
    int   prg_rises = 0, prg_cs_falls = 0;
    logic p_ext_ck, p_ext_cs, p_prg_ck, p_prg_cs;

    always @(negedge clk) begin
        if (rvalid === 1'b1) rvalid_cnt++;
        if (ext_ck === 1'b1 && p_ext_ck === 1'b0) ext_rises++;
        if (ext_cs === 1'b0 && p_ext_cs === 1'b1) begin ext_cs_falls++; ext_fall_cyc = cyc; end
        if (ext_cs === 1'b1 && p_ext_cs === 1'b0) ext_rise_cyc = cyc;
        if (prg_ck === 1'b1 && p_prg_ck === 1'b0) prg_rises++;
        if (prg_cs === 1'b0 && p_prg_cs === 1'b1) prg_cs_falls++;
        p_ext_ck = ext_ck; p_ext_cs = ext_cs; p_prg_ck = prg_ck; p_prg_cs = prg_cs;
    end

    // ---------------- bus helpers
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, output int rc);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        rc = cyc;
    endtask

    task automatic wait_resp(input int rc, output logic [31:0] rd, output logic er,
                             output int lat);
        rd = 'x; er = 1'bx; lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            req = 1'b0;
            if (rvalid === 1'b1) begin
                rd = rdata; er = err; lat = cyc - rc;
                break;
            end
        end
        #1;
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, output logic [31:0] rd, output logic er,
                          output int lat);
        int rc;
        issue(w, a, b, d, rc);
        wait_resp(rc, rd, er, lat);
    endtask

    // ---------------- tests
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if ({rvalid, err, rdata} !== 34'h0) begin
            errors++; $display("FAIL reset_resp: got %b/%b/%h expected 0/0/0", rvalid, err, rdata);
        end
        checks++;
        if (gpio !== 10'h0) begin errors++; $display("FAIL reset_gpio: got %h expected 000", gpio); end
        checks++;
        if ({ext_cs, ext_ck, ext_io_t, ext_io_o} !== 10'b1_0_1111_0000) begin
            errors++; $display("FAIL reset_ext_port: got %b expected 1011110000",
                               {ext_cs, ext_ck, ext_io_t, ext_io_o});
        end
        checks++;
        if ({prg_cs, prg_ck, prg_io_t, prg_io_o} !== 10'b1_0_1111_0000) begin
            errors++; $display("FAIL reset_prg_port: got %b expected 1011110000",
                               {prg_cs, prg_ck, prg_io_t, prg_io_o});
        end
        checks++;
        if (rvalid_cnt !== 0) begin errors++; $display("FAIL reset_idle_rvalid: got %0d pulses expected 0", rvalid_cnt); end
    endtask

    task automatic test_gpio();
        logic [31:0] rd; logic er; int lat;
        access(1'b1, 32'h1000, 4'b0011, 32'hFFFF_F3FF, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b0) begin errors++; $display("FAIL gpio_wr_resp: got lat %0d err %b expected 1 0", lat, er); end
        checks++;
        if (gpio !== 10'h3FF) begin errors++; $display("FAIL gpio_wr_pins: got %h expected 3ff", gpio); end
        access(1'b0, 32'h1000, 4'b1111, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_03FF || lat !== 1) begin
            errors++; $display("FAIL gpio_rd: got %h lat %0d expected 000003ff lat 1", rd, lat);
        end
        // Only be[1] set: bits [9:8] cleared, [7:0] kept.
        access(1'b1, 32'h1000, 4'b0010, 32'h0, rd, er, lat);
        checks++;
        if (gpio !== 10'h0FF) begin errors++; $display("FAIL gpio_be_hi: got %h expected 0ff", gpio); end
    endtask

    task automatic test_flash_read(input logic [31:0] a, input logic [31:0] exp_data,
                                   input logic [23:0] exp_faddr);
        logic [31:0] rd; logic er; int lat, rc, r0, pf0;
        r0 = ext_rises; pf0 = prg_cs_falls;
        issue(1'b0, a, 4'hF, 32'h0, rc);
        wait_resp(rc, rd, er, lat);
        checks++;
        if (rd !== exp_data || er !== 1'b0) begin
            errors++; $display("FAIL flash_data %h: got %h err %b expected %h err 0", a, rd, er, exp_data);
        end
        checks++;
        if (lat !== 98) begin errors++; $display("FAIL flash_latency %h: got %0d expected 98", a, lat); end
        checks++;
        if (cap !== {8'h6B, exp_faddr}) begin
            errors++; $display("FAIL flash_cmd_addr %h: got %h expected %h", a, cap, {8'h6B, exp_faddr});
        end
        checks++;
        if (ext_fall_cyc - rc !== 1 || ext_rise_cyc - rc !== 98) begin
            errors++; $display("FAIL flash_cs_timing %h: got fall %0d rise %0d expected 1 98",
                               a, ext_fall_cyc - rc, ext_rise_cyc - rc);
        end
        checks++;
        if (ext_rises - r0 !== 48 || prg_cs_falls !== pf0) begin
            errors++; $display("FAIL flash_sck %h: got %0d sck, %0d prg selects expected 48, 0",
                               a, ext_rises - r0, prg_cs_falls - pf0);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, f0;
        logic [31:0] bad [4];
        bad[0] = 32'h0000_0100; bad[1] = 32'h0000_0FFF;
        bad[2] = 32'h0000_1004; bad[3] = 32'h0100_2000;
        for (int i = 0; i < 4; i++) begin
            access(1'b0, bad[i], 4'hF, 32'h0, rd, er, lat);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
                errors++; $display("FAIL err_read %h: got err %b data %h lat %0d expected 1 0 1", bad[i], er, rd, lat);
            end
        end
        f0 = ext_cs_falls;
        access(1'b1, 32'h2000, 4'hF, 32'h0000_0000, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || ext_cs_falls !== f0 || gpio !== 10'h0FF) begin
            errors++; $display("FAIL err_flash_write: got err %b data %h lat %0d selects %0d gpio %h expected 1 0 1 0 0ff",
                               er, rd, lat, ext_cs_falls - f0, gpio);
        end
    endtask

    task automatic test_busy();
        logic [31:0] rd; logic er; int lat, rc, rc2, v0;
        v0 = rvalid_cnt;
        issue(1'b0, 32'h2004, 4'hF, 32'h0, rc);
        @(negedge clk); req = 1'b0;
        repeat (8) @(negedge clk);
        issue(1'b1, 32'h1000, 4'b0011, 32'h0, rc2);   // must be ignored
        wait_resp(rc, rd, er, lat);
        repeat (3) @(negedge clk);
        checks++;
        if (rd !== 32'h4433_2211 || lat !== 98) begin
            errors++; $display("FAIL busy_flash: got %h lat %0d expected 44332211 lat 98", rd, lat);
        end
        checks++;
        if (rvalid_cnt - v0 !== 1 || gpio !== 10'h0FF) begin
            errors++; $display("FAIL busy_ignored: got %0d responses gpio %h expected 1 0ff", rvalid_cnt - v0, gpio);
        end
    endtask

    task automatic test_prog_mode();
        logic [31:0] rd; logic er; int lat, rc, e0, p0;
        set_programming_mode = 1'b1;
        model_sel = 1'b1;
        e0 = ext_cs_falls; p0 = prg_rises;
        issue(1'b0, 32'h2004, 4'hF, 32'h0, rc);
        @(negedge clk); req = 1'b0;
        set_programming_mode = 1'b0;   // must not move the running read
        wait_resp(rc, rd, er, lat);
        checks++;
        if (rd !== 32'h4433_2211 || lat !== 98 || cap !== 32'h6B00_0004) begin
            errors++; $display("FAIL prog_read: got %h lat %0d bus %h expected 44332211 98 6b000004", rd, lat, cap);
        end
        checks++;
        if (ext_cs_falls !== e0 || prg_rises - p0 !== 48) begin
            errors++; $display("FAIL prog_port_only: got ext selects %0d prg sck %0d expected 0 48",
                               ext_cs_falls - e0, prg_rises - p0);
        end
        model_sel = 1'b0;
    endtask

    task automatic test_debug();
`ifdef MMU_DEBUG_EN
        logic [31:0] rd; logic er; int lat, rc;
        set_debug_mode = 1'b1;
        issue(1'b0, 32'h2FFC, 4'hF, 32'h0, rc);
        @(negedge clk); req = 1'b0;
        checks++;
        if (gpio !== 10'h3FF) begin errors++; $display("FAIL debug_pins: got %h expected 3ff", gpio); end
        wait_resp(rc, rd, er, lat);
        set_debug_mode = 1'b0;
        @(negedge clk);
        checks++;
        if (gpio !== 10'h0FF || rd !== 32'hA5A4_A7A6) begin
            errors++; $display("FAIL debug_exit: got gpio %h data %h expected 0ff a5a4a7a6", gpio, rd);
        end
`else
        set_debug_mode = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (gpio !== 10'h0FF) begin errors++; $display("FAIL debug_ignored: got %h expected 0ff", gpio); end
        set_debug_mode = 1'b0;
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat, rc, v0;
        v0 = rvalid_cnt;
        issue(1'b0, 32'h2004, 4'hF, 32'h0, rc);
        @(negedge clk); req = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ext_cs, ext_ck, ext_io_t, ext_io_o, prg_cs, prg_ck, prg_io_t, prg_io_o} !== 20'b1011110000_1011110000
            || gpio !== 10'h0 || {rvalid, err, rdata} !== 34'h0) begin
            errors++; $display("FAIL reset_mid_outputs: got ext %b prg %b gpio %h rvalid %b expected idle, 000, 0",
                               {ext_cs, ext_ck, ext_io_t, ext_io_o}, {prg_cs, prg_ck, prg_io_t, prg_io_o}, gpio, rvalid);
        end
        rst = 1'b1;
        repeat (120) @(negedge clk);
        checks++;
        if (rvalid_cnt !== v0 || ext_cs !== 1'b1) begin
            errors++; $display("FAIL reset_mid_no_resp: got %0d responses cs %b expected 0 1", rvalid_cnt - v0, ext_cs);
        end
        access(1'b0, 32'h1000, 4'hF, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || lat !== 1) begin
            errors++; $display("FAIL reset_mid_recover: got %h lat %0d expected 0 lat 1", rd, lat);
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) fmem[a] = 8'(a) ^ 8'h5A;
        fmem[4] = 8'h11; fmem[5] = 8'h22; fmem[6] = 8'h33; fmem[7] = 8'h44;

        test_reset();
        test_gpio();
        test_flash_read(32'h0000_2004, 32'h4433_2211, 24'h00_0004);
        test_flash_read(32'h0000_2FFE, 32'hA5A4_A7A6, 24'h00_0FFC);
        test_flash_read(32'h0100_1FFC, 32'hA5A4_A7A6, 24'hFF_FFFC);
        test_errors();
        test_busy();
        test_prog_mode();
        test_debug();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
